// File: rtl/intn_shift_unit.sv
// intn_shift_unit: serial shift/rotate unit, one 1-bit step per clock.
// Handshake: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Optional feature: define INTN_SHIFT_ZERO_FLAG_EN to drive zero = (result == 0);
// otherwise zero is tied low and no comparator is built.
module intn_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_LSH = 3'd0,
        OP_RSH = 3'd1,
        OP_ROL = 3'd2,
        OP_ROR = 3'd3,
        OP_ASR = 3'd4,
        OP_RCL = 3'd5,
        OP_RCR = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_e           state;
    op_e              op_r;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] d_r;
    logic             c_r;
    logic [WIDTH-1:0] d_step;
    logic             c_step;

    // One 1-bit step of the latched operation; c_step is the bit expelled
    // (for RCL/RCR it doubles as the rotating carry).
    always_comb begin
        d_step = d_r;
        c_step = c_r;
        case (op_r)
            OP_LSH: begin d_step = {d_r[WIDTH-2:0], 1'b0};       c_step = d_r[WIDTH-1]; end
            OP_RSH: begin d_step = {1'b0, d_r[WIDTH-1:1]};       c_step = d_r[0];       end
            OP_ROL: begin d_step = {d_r[WIDTH-2:0], d_r[WIDTH-1]}; c_step = d_r[WIDTH-1]; end
            OP_ROR: begin d_step = {d_r[0], d_r[WIDTH-1:1]};     c_step = d_r[0];       end
            OP_ASR: begin d_step = {d_r[WIDTH-1], d_r[WIDTH-1:1]}; c_step = d_r[0];     end
            OP_RCL: begin d_step = {d_r[WIDTH-2:0], c_r};        c_step = d_r[WIDTH-1]; end
            OP_RCR: begin d_step = {c_r, d_r[WIDTH-1:1]};        c_step = d_r[0];       end
            default: begin d_step = d_r;                         c_step = c_r;          end
        endcase
    end

    // Control FSM and working registers; result/carry are the registers themselves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_r  <= OP_NOP;
            cnt   <= '0;
            d_r   <= '0;
            c_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_r  <= a;
                        c_r  <= carry_in;
                        op_r <= op_e'(op);
                        cnt  <= amt;
                        if (amt != '0 && op_e'(op) != OP_NOP)
                            state <= SHIFT;
                        else
                            state <= DONE;
                    end
                end
                SHIFT: begin
                    d_r <= d_step;
                    c_r <= c_step;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DONE);
    assign result    = d_r;
    assign carry     = c_r;

`ifdef INTN_SHIFT_ZERO_FLAG_EN
    assign zero = (d_r == '0);
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_intn_shift_unit.sv
// tb_intn_shift_unit: directed and randomized checks of intn_shift_unit
// against an arithmetic reference model (WIDTH=8, AMT_W=4).
module tb_intn_shift_unit;

    localparam int W = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [AW-1:0] amt;
    logic          carry_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;

    int n_cmp = 0;
    int n_err = 0;

    intn_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .amt(amt), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-operation reference: computes the final value and last expelled bit directly.
    function automatic void model(input int o, input int ai, input int am, input int ci,
                                  output int res, output int cout);
        int k;
        int v9;
        longint v;
        res  = ai;
        cout = ci;
        if (o == 7 || am == 0) return;
        case (o)
            0: begin v = longint'(ai) << am; res = int'(v & 255); cout = int'((v >> 8) & 1); end
            1: begin v = (longint'(ai) << 16) >> am; res = int'((v >> 16) & 255); cout = int'((v >> 15) & 1); end
            2: begin k = am % 8; res = ((ai << k) | (ai >> (8 - k))) & 255; cout = res & 1; end
            3: begin k = am % 8; res = ((ai >> k) | (ai << (8 - k))) & 255; cout = (res >> 7) & 1; end
            4: begin
                v = longint'(ai >= 128 ? ai - 256 : ai) * 65536;
                v = v >>> am;
                res = int'((v >>> 16) & 255);
                cout = int'((v >>> 15) & 1);
            end
            5: begin
                v9 = (ai << 1) | ci; k = am % 9;
                v9 = ((v9 << k) | (v9 >> (9 - k))) & 511;
                res = v9 >> 1; cout = v9 & 1;
            end
            default: begin
                v9 = (ci << 8) | ai; k = am % 9;
                v9 = ((v9 >> k) | (v9 << (9 - k))) & 511;
                res = v9 & 255; cout = v9 >> 8;
            end
        endcase
    endfunction

    task automatic garbage_inputs();
        in_valid = 1'($urandom_range(0, 1));
        op       = 3'($urandom_range(0, 7));
        a        = 8'($urandom_range(0, 255));
        amt      = 4'($urandom_range(0, 15));
        carry_in = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic run_op(input int o, input int ai, input int am, input int ci, input int stall);
        int er, ec, ez, n;
        model(o, ai, am, ci, er, ec);
`ifdef INTN_SHIFT_ZERO_FLAG_EN
        ez = (er == 0) ? 1 : 0;
`else
        ez = 0;
`endif
        check("idle_in_ready", in_ready, 1);
        op = 3'(o); a = 8'(ai); amt = 4'(am); carry_in = 1'(ci);
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 40) begin
            check("busy_in_ready", in_ready, 0);
            garbage_inputs();
            @(negedge clk);
            n++;
        end
        check("latency", n, (o == 7 || am == 0) ? 0 : am);
        check("out_valid", out_valid, 1);
        check("result", result, er);
        check("carry", carry, ec);
        check("zero", zero, ez);
        for (int i = 0; i < stall; i++) begin
            garbage_inputs();
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, er);
            check("hold_carry", carry, ec);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; amt = '0;
        carry_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Directed cases from the reference examples.
        run_op(0, 'h81, 1, 0, 0);
        run_op(3, 'h01, 3, 0, 0);
        run_op(4, 'h90, 2, 0, 0);
        run_op(1, 'hFF, 12, 0, 0);
        run_op(5, 'h80, 2, 0, 0);
        run_op(6, 'h01, 1, 1, 0);
        run_op(7, 'h5A, 5, 1, 0);
        run_op(2, 'h81, 15, 0, 0);
        run_op(4, 'h80, 15, 1, 0);
        run_op(6, 'hA5, 9, 0, 0);
        run_op(0, 'hC3, 0, 1, 0);
        // Backpressure.
        run_op(4, 'h90, 2, 1, 5);

        // Reset in the middle of a long shift.
        op = 3'd0; a = 8'h5A; amt = 4'd9; carry_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        @(negedge clk);
        check("mid_rst_result", result, 0);
        check("mid_rst_carry", carry, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        run_op(1, 'hB7, 3, 0, 0);

        // Back-to-back zero-length requests: accept, result, idle, accept ...
        op = 3'd2; a = 8'h3C; amt = 4'd0; carry_in = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("b2b_in_ready", in_ready, (i % 2 == 0) ? 1 : 0);
            check("b2b_out_valid", out_valid, (i % 2 == 1) ? 1 : 0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
